// File: rtl/pmem_sched_pkg.sv
// Shared types and constants for the physical-memory port scheduler.
package pmem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } sched_state_t;

  // Fill bit replicated across the full byte-select bus (whole-line transfers).
  localparam logic PMEM_SEL_ALL = 1'b1;

  // Consecutive-read counter width and its saturation value.
  localparam int unsigned           STREAK_W   = 4;
  localparam logic [STREAK_W-1:0]   STREAK_SAT = '1;

endpackage

// File: rtl/pmem_grant_logic.sv
// Combinational arbitration between L2 line reads and victim writebacks,
// evaluated only while the scheduler is idle.
module pmem_grant_logic
  import pmem_sched_pkg::*;
#(
  parameter int unsigned ADR_W         = 12,
  parameter int unsigned MAX_RD_STREAK = 4
) (
  input  logic                rd_req,
  input  logic                wb_req,
  input  logic [ADR_W-1:0]    rd_adr,
  input  logic [ADR_W-1:0]    wb_adr,
  input  logic [STREAK_W-1:0] streak_cnt,
  output sched_state_t        grant_c
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_RD_STREAK);

  // Reads win unless the writeback targets the same line or has waited too long.
  always_comb begin
    grant_c = IDLE;
    if (rd_req && wb_req) begin
      if ((rd_adr == wb_adr) || (streak_cnt == STREAK_LIMIT)) begin
        grant_c = WR;
      end else begin
        grant_c = RD;
      end
    end else if (rd_req) begin
      grant_c = RD;
    end else if (wb_req) begin
      grant_c = WR;
    end
  end

endmodule

// File: rtl/pmem_scheduler.sv
// Owns the single pmem wishbone port and shares it between L2 miss reads
// and victim-cache writebacks (classic single-cycle-gap wishbone cycles).
module pmem_scheduler
  import pmem_sched_pkg::*;
#(
  parameter int unsigned ADR_W         = 12,
  parameter int unsigned DATA_W        = 128,
  parameter int unsigned SEL_W         = 16,
  parameter int unsigned MAX_RD_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [ADR_W-1:0]    rd_adr,
  output logic                rd_ack,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wb_req,
  input  logic [ADR_W-1:0]    wb_adr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                wb_ack,
  output logic                pmem_cyc,
  output logic                pmem_stb,
  output logic                pmem_we,
  output logic [SEL_W-1:0]    pmem_sel,
  output logic [ADR_W-1:0]    pmem_adr,
  output logic [DATA_W-1:0]   pmem_dat_m,
  input  logic [DATA_W-1:0]   pmem_dat_s,
  input  logic                pmem_ack,
  output logic [STREAK_W-1:0] streak_cnt
);

  sched_state_t         state_q, state_d;
  sched_state_t         grant_c;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [DATA_W-1:0]    dat_q, dat_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;

  pmem_grant_logic #(
    .ADR_W         (ADR_W),
    .MAX_RD_STREAK (MAX_RD_STREAK)
  ) u_grant (
    .rd_req     (rd_req),
    .wb_req     (wb_req),
    .rd_adr     (rd_adr),
    .wb_adr     (wb_adr),
    .streak_cnt (streak_q),
    .grant_c    (grant_c)
  );

  // State, bus-master registers and read-streak counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      streak_q <= streak_d;
    end
  end

  // Grant in IDLE, hold the bus cycle until pmem_ack, then return to IDLE.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (grant_c == RD) begin
          state_d = RD;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = rd_adr;
          if (wb_req && (streak_q != STREAK_SAT)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_c == WR) begin
          state_d  = WR;
          cyc_d    = 1'b1;
          we_d     = 1'b1;
          adr_d    = wb_adr;
          dat_d    = wb_data;
          streak_d = '0;
        end
      end
      RD, WR: begin
        if (pmem_ack) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // Completion is forwarded in the same cycle as pmem_ack, only to the owner.
  assign rd_ack     = (state_q == RD) && pmem_ack;
  assign wb_ack     = (state_q == WR) && pmem_ack;
  assign rd_data    = pmem_dat_s;

  assign pmem_cyc   = cyc_q;
  assign pmem_stb   = cyc_q;
  assign pmem_we    = we_q;
  assign pmem_sel   = {SEL_W{PMEM_SEL_ALL}};
  assign pmem_adr   = adr_q;
  assign pmem_dat_m = dat_q;
  assign streak_cnt = streak_q;

endmodule
